// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scheduler.
// The hazard_ctrl top optionally adds perf counters under HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } haz_state_t;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic pipe_en;
    logic ex_hold;
    logic hazflush;
    logic flush;
  } pipe_ctrl_t;

  // Free-running pipeline: everything advances, no bubble, no flush.
  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en:    1'b1,
    ifid_en:  1'b1,
    pipe_en:  1'b1,
    ex_hold:  1'b0,
    hazflush: 1'b1,
    flush:    1'b0
  };

  localparam pipe_ctrl_t CTRL_RST = '{
    pc_en:    1'b0,
    ifid_en:  1'b0,
    pipe_en:  1'b0,
    ex_hold:  1'b0,
    hazflush: 1'b1,
    flush:    1'b0
  };

  // Front end and EX frozen while a multicycle op occupies EX.
  localparam pipe_ctrl_t CTRL_MC_STALL = '{
    pc_en:    1'b0,
    ifid_en:  1'b0,
    pipe_en:  1'b0,
    ex_hold:  1'b1,
    hazflush: 1'b1,
    flush:    1'b0
  };

  // One-cycle load-use stall: hold PC and IF/ID, push a bubble into EX.
  function automatic pipe_ctrl_t ctrl_load_use();
    pipe_ctrl_t c;
    c          = CTRL_RUN;
    c.pc_en    = 1'b0;
    c.ifid_en  = 1'b0;
    c.hazflush = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparison between the ID sources and a load in EX.
// Kept standalone so a forwarding unit can reuse the same match logic.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_memrd_i,
  output logic              lu_c_o
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign rd_nonzero = (ex_rd_i != REG_AW'(REG_ZERO));
  assign rs1_hit    = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  assign lu_c_o     = ex_memrd_i && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline scheduler: load-use stall, branch flush, multicycle freeze.
// Define HAZARD_PERF_CNT_EN to add stall/flush/multicycle performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memrd,
  input  logic              ex_br_taken,
  input  logic              ex_mc_start,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              pipe_en,
  output logic              ex_hold,
  output logic              hazflush,
  output logic              flush,
  output logic              mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       mc_cnt
`endif
);

  localparam int unsigned PERF_W = 32;

  haz_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pipe_ctrl_t       ctrl_c;
  logic             mc_busy_c;
  logic             mc_accept_c;
  logic             lu_c;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_lu (
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rs1_used_i (id_rs1_used),
    .id_rs2_used_i (id_rs2_used),
    .ex_rd_i       (ex_rd),
    .ex_memrd_i    (ex_memrd),
    .lu_c_o        (lu_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: MC_BUSY > ex_mc_start > ex_br_taken > load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctrl_c      = CTRL_RUN;
    mc_busy_c   = 1'b0;
    mc_accept_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_mc_start) begin
          ctrl_c      = CTRL_MC_STALL;
          mc_busy_c   = 1'b1;
          mc_accept_c = 1'b1;
          state_d     = MC_BUSY;
          cnt_d       = CNT_W'(MC_LAT - 1);
        end else if (ex_br_taken) begin
          ctrl_c.flush = 1'b1;
        end else if (lu_c) begin
          ctrl_c = ctrl_load_use();
        end
      end
      MC_BUSY: begin
        ctrl_c    = CTRL_MC_STALL;
        mc_busy_c = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
    endcase
    // Reset overrides everything combinationally, not just at the next edge.
    if (rst) begin
      ctrl_c      = CTRL_RST;
      mc_busy_c   = 1'b0;
      mc_accept_c = 1'b0;
    end
  end

  assign pc_en    = ctrl_c.pc_en;
  assign ifid_en  = ctrl_c.ifid_en;
  assign pipe_en  = ctrl_c.pipe_en;
  assign ex_hold  = ctrl_c.ex_hold;
  assign hazflush = ctrl_c.hazflush;
  assign flush    = ctrl_c.flush;
  assign mc_busy  = mc_busy_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q, mc_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mc_cnt_q    <= '0;
    end else begin
      if (!ctrl_c.pc_en) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (ctrl_c.flush)  flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      if (mc_accept_c)   mc_cnt_q    <= mc_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mc_cnt    = mc_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = mc_accept_c & (PERF_W != 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_LAT=4).
// Covers HAZARD_PERF_CNT_EN counters when the macro is defined.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;

  // Expected output vectors {pc_en, ifid_en, pipe_en, ex_hold, hazflush, flush, mc_busy}
  localparam logic [6:0] V_RST   = 7'b0000100;
  localparam logic [6:0] V_RUN   = 7'b1110100;
  localparam logic [6:0] V_LU    = 7'b0010000;
  localparam logic [6:0] V_FLUSH = 7'b1110110;
  localparam logic [6:0] V_MC    = 7'b0001101;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_rs1_used, id_rs2_used, ex_memrd, ex_br_taken, ex_mc_start;
  logic              pc_en, ifid_en, pipe_en, ex_hold, hazflush, flush, mc_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cnt, flush_cnt, mc_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  hazard_ctrl #(
    .REG_AW(REG_AW),
    .MC_LAT(4),
    .CNT_W (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_memrd    (ex_memrd),
    .ex_br_taken (ex_br_taken),
    .ex_mc_start (ex_mc_start),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .pipe_en     (pipe_en),
    .ex_hold     (ex_hold),
    .hazflush    (hazflush),
    .flush       (flush),
    .mc_busy     (mc_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .mc_cnt      (mc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({pc_en, ifid_en, pipe_en, ex_hold, hazflush, flush, mc_busy});
  endfunction

  // Advance to just after the next rising edge; inputs are then driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_memrd = 1'b0; ex_br_taken = 1'b0; ex_mc_start = 1'b0;
  endtask

  task automatic set_lu(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs2);
    ex_memrd = 1'b1; ex_rd = rd; id_rs2_used = 1'b1; id_rs2 = rs2;
  endtask

  // A bubble and a flush in the same cycle would be contradictory.
  always @(negedge clk) begin
    if (!rst) check_eq("flush_with_bubble", 32'(flush & ~hazflush), 32'd0);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    check_eq("reset_forced", outs(), 32'(V_RST));
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("after_reset", outs(), 32'(V_RUN));

    // Load-use via rs2, then recovery once the bubble clears ex_memrd.
    step(); set_lu(5'd5, 5'd5); #1;
    check_eq("lu_rs2_stall", outs(), 32'(V_LU));
    step(); idle_inputs(); #1;
    check_eq("lu_recover", outs(), 32'(V_RUN));

    step(); set_lu(5'd0, 5'd0); #1;
    check_eq("lu_x0_nostall", outs(), 32'(V_RUN));

    step(); idle_inputs(); ex_memrd = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1; #1;
    check_eq("lu_rs1_stall", outs(), 32'(V_LU));
    step(); id_rs1_used = 1'b0; #1;
    check_eq("lu_rs1_unused", outs(), 32'(V_RUN));
    step(); idle_inputs(); set_lu(5'd9, 5'd8); #1;
    check_eq("lu_addr_miss", outs(), 32'(V_RUN));
    step(); ex_memrd = 1'b0; id_rs2 = 5'd9; #1;
    check_eq("lu_not_load", outs(), 32'(V_RUN));

    // Branch beats load-use, one cycle only.
    step(); idle_inputs(); set_lu(5'd5, 5'd5); ex_br_taken = 1'b1; #1;
    check_eq("br_over_lu", outs(), 32'(V_FLUSH));
    step(); idle_inputs(); #1;
    check_eq("br_one_cycle", outs(), 32'(V_RUN));

    // Multicycle: start at t, stall through t+3, branch at t+2 ignored.
    step(); ex_mc_start = 1'b1; ex_br_taken = 1'b1; #1;
    check_eq("mc_t0", outs(), 32'(V_MC));
    step(); idle_inputs(); ex_mc_start = 1'b1; #1;
    check_eq("mc_t1", outs(), 32'(V_MC));
    step(); idle_inputs(); ex_br_taken = 1'b1; set_lu(5'd3, 5'd3); #1;
    check_eq("mc_t2_br_ignored", outs(), 32'(V_MC));
    step(); idle_inputs(); #1;
    check_eq("mc_t3", outs(), 32'(V_MC));
    step(); #1;
    check_eq("mc_t4_release", outs(), 32'(V_RUN));
    step(); #1;
    check_eq("mc_t5_idle", outs(), 32'(V_RUN));

    // Reset in the middle of a multicycle sequence.
    step(); ex_mc_start = 1'b1; #1;
    check_eq("mcrst_t0", outs(), 32'(V_MC));
    step(); ex_mc_start = 1'b0; rst = 1'b1; #1;
    check_eq("mcrst_t1_forced", outs(), 32'(V_RST));
    step(); rst = 1'b0; #1;
    check_eq("mcrst_t2_run", outs(), 32'(V_RUN));
    step(); #1;
    check_eq("mcrst_t3_run", outs(), 32'(V_RUN));

`ifdef HAZARD_PERF_CNT_EN
    // 1 load-use + 1 multicycle (4 stalls) + 2 branches.
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0; #1;
    check_eq("perf_cleared", stall_cnt | flush_cnt | mc_cnt, 32'd0);
    step(); set_lu(5'd4, 5'd4); #1;
    step(); idle_inputs(); ex_mc_start = 1'b1; #1;
    step(); idle_inputs(); #1;
    step(); step(); step();
    ex_br_taken = 1'b1; #1;
    step(); ex_br_taken = 1'b0; #1;
    step(); ex_br_taken = 1'b1; #1;
    step(); idle_inputs(); #1;
    check_eq("perf_stall_cnt", stall_cnt, 32'd5);
    check_eq("perf_flush_cnt", flush_cnt, 32'd2);
    check_eq("perf_mc_cnt", mc_cnt, 32'd1);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
